des_subkey_gen: RTL
===================

# des_subkey_gen

Sequential DES key-schedule engine. It accepts one 64-bit key and emits the 16 round subkeys, one per handshake, over a valid/ready stream. In encrypt mode it emits K1..K16; in decrypt mode it emits K16..K1. It is the key-side producer for the round datapath, where each subkey is XORed with E(R) ahead of the eight S-box lookups.

## Interface
Parameters:
- None. Round count (16), PC-1, PC-2 and the shift schedule are fixed constants.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `key_valid`  in  1  `key` and `decrypt` are valid.
- `key_ready`  out  1  engine is idle and can accept a key.
- `key`  in  [0:63]  DES key in DES bit order (bit 0 = DES bit 1); parity bits 7, 15, …, 63 are ignored.
- `decrypt`  in  1  0 = emit K1..K16; 1 = emit K16..K1. Sampled only on key acceptance.
- `sk_valid`  out  1  `subkey`, `round` and `last` are valid.
- `sk_ready`  in  1  downstream accepts the current subkey.
- `subkey`  out  [0:47]  PC-2(C,D) of the current round.
- `round`  out  [0:3]  emission index, 0..15.
- `last`  out  1  high when `round` = 15 and `sk_valid` = 1.

## Operation
- **States:**
  - IDLE: `key_ready` = 1, `sk_valid` = 0.
  - RUN: `key_ready` = 0, `sk_valid` = 1.
- **IDLE → RUN** on `key_valid` & `key_ready`. On that edge:
  - (C,D) ← PC-1(`key`), then the first-round adjust is applied.
  - Encrypt: rotate C and D left by 1.
  - Decrypt: no rotation, because C16 = C0 and D16 = D0.
  - `round` ← 0; mode is latched.
- **RUN, on `sk_valid` & `sk_ready` with `round` < 15:**
  - `round` increments.
  - C and D are rotated by the amount for the new index i (1..15).
  - Encrypt: rotate left by 1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
  - Decrypt: rotate right by 1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
- **RUN → IDLE** on a handshake with `round` = 15. On that edge `round` ← 0.
- `subkey` = PC-2(C,D) is combinational from the C/D registers. It is glitch-free relative to handshakes because it is registered-input only.
- **Stall:** while `sk_ready` = 0, C, D, `round`, `subkey` and `last` hold.
- **Keys during RUN:** `key_valid` in RUN is ignored (`key_ready` = 0). A key held valid is accepted once IDLE is re-entered.
- **Reset mid-RUN** aborts the schedule. No further subkeys are emitted until a new key is accepted.

## Timing
- **Reset values:**
  - `key_ready` = 1
  - `sk_valid` = 0
  - `round` = 0
  - `last` = 0
  - C = D = 0, so `subkey` = 0
- **Latency:** key accepted at edge t → first subkey valid after t, i.e. in cycle t+1.
- **Throughput:** with `sk_ready` held at 1, one subkey per cycle; the 16 subkeys occupy cycles t+1..t+16.
- **Idle gap:** `key_ready` rises the cycle after the final handshake. A back-to-back key is accepted at edge t+17, giving 17 cycles per key minimum.
- **No combinational paths:**
  - No path from `key_valid` to `key_ready`.
  - No path from `sk_ready` to `sk_valid`.

## Structure
- **Shared package `des_pkg`:**
  - PC1 table (56 entries)
  - PC2 table (48 entries)
  - SHIFTS[0:15] = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1
  - state encodings IDLE/RUN
  - round width constant (4)
- **Sub-module `des_pc2`:** pure combinational permutation, [0:55] → [0:47]. It is reused by the round datapath and the test bench model.
- **PC-1** is inlined in this block.
- The rotators are two 28-bit muxes covering left/right by 1/2.

## Test plan
- **Encrypt order:** `key` = 64'h133457799BBCDFF1, `decrypt` = 0, `sk_ready` = 1 → expected subkeys:
  - round 0: 48'h1B02EFFC7072
  - round 1: 48'h79AED9DBC9E5
  - round 15: 48'hCB3D8B0E17F5, with `last` = 1
  - `key_ready` = 1 on the next cycle
- **Decrypt order:** same key, `decrypt` = 1 → round 0 = 48'hCB3D8B0E17F5; round 15 = 48'h1B02EFFC7072. All 16 subkeys equal the encrypt sequence reversed.
- **Stall and hold:** toggle `sk_ready` randomly (~50%) → the sequence is identical to the first scenario, and outputs hold bit-stable during stalls.
- **Keys while busy:** assert `key_valid` with a new key during RUN → it is ignored until the final handshake, then accepted 1 cycle later. The second sequence matches the model.
- **Reset mid-run:** assert `rst` after round 7 → `sk_valid` = 0 and `key_ready` = 1 immediately. A fresh key then restarts at round 0 with the correct K1.
- **Parity ignored:** `key` = 64'h133457799BBCDFF1 XOR 64'h0101010101010101 → subkeys identical to the first scenario.

Source files
------------

// File: rtl/des_pkg.sv
// Shared DES key-schedule constants: PC-1/PC-2 tables (1-based DES bit numbers),
// per-round left-shift schedule, engine state encoding, round width, and a
// 28-bit half rotator (left/right by 1/2) used by the subkey engine.
package des_pkg;

  localparam int ROUND_W    = 4;
  localparam int NUM_ROUNDS = 16;

  localparam int unsigned PC1 [0:55] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int unsigned PC2 [0:47] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  localparam int unsigned SHIFTS [0:15] = '{
    1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1
  };

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Index 0 is the leftmost DES bit, so "left" moves bits toward index 0.
  function automatic logic [0:27] rot28(input logic [0:27] x, input logic left,
                                        input logic two);
    logic [0:27] r;
    case ({left, two})
      2'b10:   r = {x[1:27], x[0]};
      2'b11:   r = {x[2:27], x[0:1]};
      2'b00:   r = {x[27], x[0:26]};
      default: r = {x[26:27], x[0:25]};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/des_subkey_gen_if.sv
// Key-in / subkey-out valid-ready bundle for the DES key-schedule engine.
// master: key source and subkey sink (drives key_valid/key/decrypt/sk_ready).
// slave: the engine (drives key_ready/sk_valid/subkey/round/last).
interface des_subkey_gen_if;
  import des_pkg::*;

  logic               key_valid;
  logic               key_ready;
  logic [0:63]        key;
  logic               decrypt;
  logic               sk_valid;
  logic               sk_ready;
  logic [0:47]        subkey;
  logic [0:ROUND_W-1] round;
  logic               last;

  modport master (
    output key_valid, key, decrypt, sk_ready,
    input  key_ready, sk_valid, subkey, round, last
  );

  modport slave (
    input  key_valid, key, decrypt, sk_ready,
    output key_ready, sk_valid, subkey, round, last
  );

endinterface

// File: rtl/des_pc2.sv
// DES permuted choice 2: selects 48 subkey bits from the 56-bit (C,D) pair.
// Ports: cd_i [0:55] = {C,D}; k_o [0:47] = round subkey. Pure combinational,
// zero latency, no flow control.
module des_pc2
  import des_pkg::*;
(
  input  logic [0:55] cd_i,
  output logic [0:47] k_o
);

  for (genvar j = 0; j < 48; j++) begin : g_pc2
    assign k_o[j] = cd_i[PC2[j] - 1];
  end

endmodule

// File: rtl/des_subkey_gen.sv
// DES key schedule: accepts one key, emits 16 subkeys (K1..K16 or K16..K1).
// Ports: clk, rst (async active-high), bus (slave side of des_subkey_gen_if).
// First subkey one cycle after key acceptance; holds all outputs while sk_ready=0.
module des_subkey_gen
  import des_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  des_subkey_gen_if.slave bus
);

  state_t             state_q, state_d;
  logic [0:55]        cd_q, cd_d;
  logic [0:55]        pc1_cd;
  logic [ROUND_W-1:0] round_q, round_d;
  logic [ROUND_W-1:0] round_nxt;
  logic               dec_q, dec_d;
  logic               step_two;
  logic [0:47]        subkey_w;
  logic               unused_parity;

  // PC-1 drops the parity bits; they are folded here only to mark them unused.
  for (genvar i = 0; i < 56; i++) begin : g_pc1
    assign pc1_cd[i] = bus.key[PC1[i] - 1];
  end
  assign unused_parity = ^{bus.key[7], bus.key[15], bus.key[23], bus.key[31],
                           bus.key[39], bus.key[47], bus.key[55], bus.key[63]};

  // The shift schedule is palindromic over indices 1..15, so the decrypt walk
  // (right shifts undoing rounds 16..2) uses the same table entry as encrypt.
  assign round_nxt = round_q + ROUND_W'(1);
  assign step_two  = (SHIFTS[round_nxt] == 2);

  always_comb begin
    state_d = state_q;
    cd_d    = cd_q;
    round_d = round_q;
    dec_d   = dec_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.key_valid) begin
          state_d = ST_RUN;
          dec_d   = bus.decrypt;
          round_d = '0;
          // Decrypt starts at K16 whose (C16,D16) equals (C0,D0): no rotate.
          if (bus.decrypt) begin
            cd_d = pc1_cd;
          end else begin
            cd_d = {rot28(pc1_cd[0:27], 1'b1, 1'b0), rot28(pc1_cd[28:55], 1'b1, 1'b0)};
          end
        end
      end
      ST_RUN: begin
        if (bus.sk_ready) begin
          if (round_q == ROUND_W'(NUM_ROUNDS - 1)) begin
            state_d = ST_IDLE;
            round_d = '0;
          end else begin
            round_d = round_nxt;
            cd_d    = {rot28(cd_q[0:27], ~dec_q, step_two),
                       rot28(cd_q[28:55], ~dec_q, step_two)};
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cd_q    <= '0;
      round_q <= '0;
      dec_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cd_q    <= cd_d;
      round_q <= round_d;
      dec_q   <= dec_d;
    end
  end

  des_pc2 u_pc2 (
    .cd_i (cd_q),
    .k_o  (subkey_w)
  );

  assign bus.subkey    = subkey_w;
  assign bus.key_ready = (state_q == ST_IDLE);
  assign bus.sk_valid  = (state_q == ST_RUN);
  assign bus.round     = round_q;
  assign bus.last      = (state_q == ST_RUN) && (round_q == ROUND_W'(NUM_ROUNDS - 1));

endmodule
